// File: rtl/spart_pkg.sv
// Shared types, address map and baud divisor table for the SPART bus scheduler.
package spart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    StCfgLo,
    StCfgHi,
    StIdle,
    StRxRd,
    StTxWr
  } sched_state_t;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  function automatic logic [15:0] divisor(input logic [1:0] br_cfg);
    logic [15:0] div;
    case (br_cfg)
      2'b00:   div = 16'h28B1;
      2'b01:   div = 16'h1458;
      2'b10:   div = 16'h0A2C;
      default: div = 16'h0516;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/spart_hold_reg.sv
// One-entry byte buffer; load wins over clear, though callers never assert both.
module spart_hold_reg
  import spart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear,
  output logic [DATA_W-1:0] data,
  output logic              full
);

  logic [DATA_W-1:0] data_q;
  logic              full_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load) begin
      data_q <= load_data;
      full_q <= 1'b1;
    end else if (clear) begin
      full_q <= 1'b0;
    end
  end

  assign data = data_q;
  assign full = full_q;

endmodule

// File: rtl/spart_io_sched.sv
// SPART bus owner: programs the baud divisor, then schedules single-cycle RX reads
// and TX writes between the two client streams, alternating when both are eligible.
module spart_io_sched
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       cfg_done
);

  sched_state_t state_q;
  logic [1:0]   cfg_q;
  logic         cfg_done_q;
  logic         last_rx_q;

  logic         tx_full, rx_full;
  logic [7:0]   tx_hold;
  logic         rx_elig, tx_elig;
  logic         drive;
  logic [7:0]   drive_val;
  logic [15:0]  div;

  assign div      = divisor(br_cfg);
  assign tx_ready = cfg_done_q && !tx_full;
  assign rx_valid = rx_full;
  assign cfg_done = cfg_done_q;
  assign rx_elig  = rda && !rx_full;
  assign tx_elig  = tbr && tx_full;

  spart_hold_reg u_tx_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_valid && tx_ready),
    .load_data (tx_data),
    .clear     (state_q == StTxWr),
    .data      (tx_hold),
    .full      (tx_full)
  );

  spart_hold_reg u_rx_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (state_q == StRxRd),
    .load_data (databus),
    .clear     (rx_valid && rx_ready),
    .data      (rx_data),
    .full      (rx_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StCfgLo;
      cfg_q      <= 2'b00;
      cfg_done_q <= 1'b0;
      last_rx_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StCfgLo: state_q <= StCfgHi;
        StCfgHi: begin
          cfg_q      <= br_cfg;
          cfg_done_q <= 1'b1;
          state_q    <= StIdle;
        end
        StIdle: begin
          if (br_cfg != cfg_q) begin
            cfg_done_q <= 1'b0;
            state_q    <= StCfgLo;
          end else if (rx_elig && (!tx_elig || !last_rx_q)) begin
            state_q <= StRxRd;
          end else if (tx_elig) begin
            state_q <= StTxWr;
          end
        end
        StRxRd: begin
          last_rx_q <= 1'b1;
          state_q   <= StIdle;
        end
        StTxWr: begin
          last_rx_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StCfgLo;
      endcase
    end
  end

  // Bus strobes are gated by rst so a held reset shows idle bus values.
  always_comb begin
    iocs      = 1'b0;
    drive     = 1'b0;
    ioaddr    = ADDR_DATA;
    drive_val = tx_hold;
    if (rst) begin
      unique case (state_q)
        StCfgLo: begin
          iocs      = 1'b1;
          drive     = 1'b1;
          ioaddr    = ADDR_DBL;
          drive_val = div[7:0];
        end
        StCfgHi: begin
          iocs      = 1'b1;
          drive     = 1'b1;
          ioaddr    = ADDR_DBH;
          drive_val = div[15:8];
        end
        StRxRd:  iocs = 1'b1;
        StTxWr: begin
          iocs  = 1'b1;
          drive = 1'b1;
        end
        default: ;
      endcase
    end
    iorw = !drive;
  end

  assign databus = drive ? drive_val : 8'hzz;

endmodule

// File: tb/tb_spart_io_sched.sv
// Directed bench for spart_io_sched: boot, echo, RX backpressure, fairness,
// reconfiguration, reset during a write, and the reset-time tie-break.
module tb_spart_io_sched;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda, tbr;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, cfg_done;

  logic [7:0] rx_byte;
  logic       probe_en;
  logic [7:0] probe_val;
  int         rd_cnt = 0;
  int         errors = 0;
  int         checks = 0;

  // SPART model drives the bus during reads; the probe checks the bus is released.
  assign databus = (iocs && iorw) ? rx_byte : (probe_en ? probe_val : 8'hzz);

  spart_io_sched dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rda      (rda),
    .tbr      (tbr),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .cfg_done (cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rst && iocs && iorw) rd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [1:0] fair_exp [8];

  initial begin
    fair_exp = '{2'b10, 2'b01, 2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 2'b01};
    rst = 0; br_cfg = 2'b10; rda = 0; tbr = 0; tx_valid = 0; tx_data = 0;
    rx_ready = 0; rx_byte = 0; probe_en = 0; probe_val = 0;
    repeat (3) @(negedge clk);
    chk("rst_iocs", 32'(iocs), 0);
    chk("rst_iorw", 32'(iorw), 1);
    chk("rst_ioaddr", 32'(ioaddr), 0);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_cfg_done", 32'(cfg_done), 0);

    // Boot with br_cfg=10: 0x2C to DBL, 0x0A to DBH.
    rst = 1; #1;
    chk("boot_lo_iocs", 32'(iocs), 1);
    chk("boot_lo_iorw", 32'(iorw), 0);
    chk("boot_lo_addr", 32'(ioaddr), 2);
    chk("boot_lo_data", 32'(databus), 'h2C);
    chk("boot_lo_done", 32'(cfg_done), 0);
    @(negedge clk);
    chk("boot_hi_iocs", 32'(iocs), 1);
    chk("boot_hi_addr", 32'(ioaddr), 3);
    chk("boot_hi_data", 32'(databus), 'h0A);
    @(negedge clk);
    chk("boot_done", 32'(cfg_done), 1);
    chk("boot_idle_iocs", 32'(iocs), 0);
    chk("boot_tx_ready", 32'(tx_ready), 1);
    probe_en = 1; probe_val = 8'hA5; #1;
    chk("idle_bus_released", 32'(databus), 'hA5);
    probe_en = 0;

    // Echo: read 0x5A, feed it back as a TX write.
    rx_byte = 8'h5A; rda = 1;
    @(negedge clk);
    chk("echo_rd_iocs", 32'(iocs), 1);
    chk("echo_rd_iorw", 32'(iorw), 1);
    chk("echo_rd_addr", 32'(ioaddr), 0);
    chk("echo_rd_valid_early", 32'(rx_valid), 0);
    rda = 0;
    @(negedge clk);
    chk("echo_rx_valid", 32'(rx_valid), 1);
    chk("echo_rx_data", 32'(rx_data), 'h5A);
    chk("echo_gap_iocs", 32'(iocs), 0);
    rx_ready = 1; tx_valid = 1; tx_data = 8'h5A;
    @(negedge clk);
    rx_ready = 0; tx_valid = 0;
    chk("echo_rx_popped", 32'(rx_valid), 0);
    chk("echo_tx_held", 32'(tx_ready), 0);
    tbr = 1;
    @(negedge clk);
    chk("echo_wr_iocs", 32'(iocs), 1);
    chk("echo_wr_iorw", 32'(iorw), 0);
    chk("echo_wr_addr", 32'(ioaddr), 0);
    chk("echo_wr_data", 32'(databus), 'h5A);
    tbr = 0;
    @(negedge clk);
    chk("echo_tx_ready_back", 32'(tx_ready), 1);
    chk("echo_after_iocs", 32'(iocs), 0);
    chk("echo_read_count", 32'(rd_cnt), 1);

    // RX backpressure: rda held, no pop -> a single read.
    rx_byte = 8'h11; rda = 1;
    repeat (6) @(negedge clk);
    chk("bp_read_count", 32'(rd_cnt), 2);
    chk("bp_rx_valid", 32'(rx_valid), 1);
    chk("bp_rx_data", 32'(rx_data), 'h11);
    rx_byte = 8'h22; rx_ready = 1;
    @(negedge clk);
    rx_ready = 0;
    chk("bp_popped", 32'(rx_valid), 0);
    chk("bp_gap_iocs", 32'(iocs), 0);
    @(negedge clk);
    chk("bp_reread_iocs", 32'(iocs), 1);
    chk("bp_reread_iorw", 32'(iorw), 1);
    rda = 0;
    @(negedge clk);
    chk("bp_reread_data", 32'(rx_data), 'h22);
    chk("bp_read_count2", 32'(rd_cnt), 3);

    // Fairness: last served RX, so TX goes first, then strict alternation.
    rx_ready = 1; tx_valid = 1; tx_data = 8'h77;
    @(negedge clk);
    rda = 1; tbr = 1; rx_byte = 8'h33;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("fair_cycle%0d", i), 32'({iocs, iorw}), 32'(fair_exp[i]));
    end
    rda = 0; tbr = 0; tx_valid = 0;

    // Reconfigure 10 -> 00 with a TX byte pending.
    @(negedge clk);
    rx_ready = 0; br_cfg = 2'b00;
    @(negedge clk);
    chk("rc0_done_low", 32'(cfg_done), 0);
    chk("rc0_lo_addr", 32'(ioaddr), 2);
    chk("rc0_lo_data", 32'(databus), 'hB1);
    @(negedge clk);
    chk("rc0_hi_data", 32'(databus), 'h28);
    @(negedge clk);
    chk("rc0_done_high", 32'(cfg_done), 1);
    chk("rc0_tx_pending", 32'(tx_ready), 0);
    rda = 1; rx_byte = 8'h44;
    @(negedge clk);
    rda = 0;
    @(negedge clk);
    chk("rc1_rx_held", 32'(rx_valid), 1);

    // Reconfigure 00 -> 11; holds survive, pending TX goes out afterwards.
    br_cfg = 2'b11;
    chk("rc1_done_detect", 32'(cfg_done), 1);
    @(negedge clk);
    chk("rc1_done_low", 32'(cfg_done), 0);
    chk("rc1_lo_addr", 32'(ioaddr), 2);
    chk("rc1_lo_data", 32'(databus), 'h16);
    @(negedge clk);
    chk("rc1_hi_addr", 32'(ioaddr), 3);
    chk("rc1_hi_data", 32'(databus), 'h05);
    @(negedge clk);
    chk("rc1_done_high", 32'(cfg_done), 1);
    chk("rc1_rx_kept", 32'(rx_data), 'h44);
    chk("rc1_tx_kept", 32'(tx_ready), 0);
    tbr = 1;
    @(negedge clk);
    chk("rc1_wr_iorw", 32'(iorw), 0);
    chk("rc1_wr_data", 32'(databus), 'h77);

    // Reset in the middle of that TX_WR.
    rst = 0; tbr = 0;
    @(negedge clk);
    chk("mid_rst_iocs", 32'(iocs), 0);
    chk("mid_rst_iorw", 32'(iorw), 1);
    chk("mid_rst_addr", 32'(ioaddr), 0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 0);
    chk("mid_rst_rx_data", 32'(rx_data), 0);
    chk("mid_rst_cfg_done", 32'(cfg_done), 0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 0);
    rst = 1; #1;
    chk("reboot_lo_data", 32'(databus), 'h16);
    @(negedge clk);
    chk("reboot_hi_data", 32'(databus), 'h05);
    @(negedge clk);
    chk("reboot_done", 32'(cfg_done), 1);
    chk("reboot_tx_empty", 32'(tx_ready), 1);

    // Tie straight after reset: last served is TX, so RX goes first.
    tx_valid = 1; tx_data = 8'hC3;
    @(negedge clk);
    tx_valid = 0;
    chk("tie_tx_loaded", 32'(tx_ready), 0);
    rda = 1; tbr = 1; rx_byte = 8'h6E;
    @(negedge clk);
    chk("tie_first_iocs", 32'(iocs), 1);
    chk("tie_first_iorw", 32'(iorw), 1);
    rda = 0;
    @(negedge clk);
    chk("tie_gap_iocs", 32'(iocs), 0);
    @(negedge clk);
    chk("tie_second_iorw", 32'(iorw), 0);
    chk("tie_second_data", 32'(databus), 'hC3);
    tbr = 0;
    @(negedge clk);
    chk("tie_rx_data", 32'(rx_data), 'h6E);
    chk("tie_tx_ready", 32'(tx_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
